// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART 8N1 program loader writing little-endian 32-bit words to memory, then pulsing CPU_start.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MAX_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        CPU_start,
  output logic        busy,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_DATA, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE, S_ERROR
  } state_t;

  rx_state_t     r_rx_state, w_rx_next;
  logic          r_rx_meta, r_rx_sync;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_rx_shift;
  logic          w_cnt_full, w_cnt_half, w_byte_valid, w_frame_err;

  state_t        r_state, w_next;
  logic [15:0]   r_len, r_words, w_len_n;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_word;
  logic [31:0]   r_wdata, r_addr;
  logic          w_len_bad, w_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  // two-flop synchroniser for the asynchronous serial input, idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_cnt_full = r_clk_cnt == C_FULL;
  assign w_cnt_half = r_clk_cnt == C_HALF;

  // receiver state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  // receiver next state: start re-checked at half bit, data and stop sampled mid-bit
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_cnt_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_cnt_full && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_cnt_full) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // receiver bit timer and LSB-first shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_START: r_clk_cnt <= w_cnt_half ? '0 : r_clk_cnt + 1'b1;
        RX_DATA: begin
          r_clk_cnt <= w_cnt_full ? '0 : r_clk_cnt + 1'b1;
          if (w_cnt_full) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 1'b1;
          end
        end
        RX_STOP: r_clk_cnt <= w_cnt_full ? '0 : r_clk_cnt + 1'b1;
        default: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

  // receiver outputs: byte strobe or framing error at the stop-bit sample
  always_comb begin
    w_byte_valid = r_rx_state == RX_STOP && w_cnt_full && r_rx_sync;
    w_frame_err  = r_rx_state == RX_STOP && w_cnt_full && !r_rx_sync;
  end

  assign w_len_n   = {r_rx_shift, r_len[7:0]};
  assign w_len_bad = w_len_n == 16'd0 || {1'b0, w_len_n} > 17'(MAX_WORDS);
  assign w_last    = r_words + 16'd1 == r_len;

  // loader state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // loader next state; a framing error anywhere is fatal until reset
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_byte_valid) w_next = S_LEN_HI;
      S_LEN_HI: if (w_byte_valid) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (w_byte_valid && r_byte_idx == 2'd3) w_next = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
      S_WRITE:  w_next = w_last ? S_CHECK : S_DATA;
      S_CHECK:  if (w_byte_valid) w_next = r_rx_shift == r_csum ? S_DONE : S_ERROR;
`else
      S_WRITE:  w_next = w_last ? S_DONE : S_DATA;
`endif
      S_DONE:   w_next = S_IDLE;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_IDLE;
    endcase
    if (w_frame_err) w_next = S_ERROR;
  end

  // loader datapath: length capture, word assembly, write address/data, word count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_words    <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_byte_valid) r_len <= {8'h00, r_rx_shift};
        S_LEN_HI: if (w_byte_valid && !w_len_bad) begin
          r_len      <= w_len_n;
          r_words    <= '0;
          r_byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
        S_DATA: if (w_byte_valid) begin
          r_word     <= {r_rx_shift, r_word[23:8]};
          r_byte_idx <= r_byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_csum     <= r_csum ^ r_rx_shift;
`endif
          if (r_byte_idx == 2'd3) begin
            r_wdata <= {r_rx_shift, r_word};
            r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
          end
        end
        S_WRITE: r_words <= r_words + 16'd1;
        default: ;
      endcase
    end
  end

  // loader outputs decoded from state
  always_comb begin
    Ext_MemWrite = r_state == S_WRITE;
    CPU_start    = r_state == S_DONE;
    load_error   = r_state == S_ERROR;
`ifdef LOADER_CHECKSUM_EN
    busy = r_state == S_LEN_HI || r_state == S_DATA || r_state == S_WRITE || r_state == S_CHECK;
`else
    busy = r_state == S_LEN_HI || r_state == S_DATA || r_state == S_WRITE;
`endif
  end

  assign Ext_WriteData = r_wdata;
  assign Ext_DataAdr   = r_addr;
  assign words_loaded  = r_words;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed self-checking bench for uart_prog_loader (BASE_ADDR 0x100, 16 clocks per bit).
module tb_uart_prog_loader;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        Ext_MemWrite, CPU_start, busy, load_error;
  logic [31:0] Ext_WriteData, Ext_DataAdr;
  logic [15:0] words_loaded;

  int          n_tests = 0, n_fail = 0;
  int          n_wr = 0, n_start = 0, cyc = 0, last_wr_cyc = 0, last_start_cyc = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [31:0] img [4];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(256), .BASE_ADDR(32'h100)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
    .CPU_start(CPU_start), .busy(busy), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // log every write strobe and start pulse, sampled away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (Ext_MemWrite) begin
      if (n_wr < 64) begin
        log_addr[n_wr] = Ext_DataAdr;
        log_data[n_wr] = Ext_WriteData;
      end
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (CPU_start) begin
      n_start++;
      last_start_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx = stop;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1);
  endtask

  task automatic send_image(input int n);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
`endif
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int k = 0; k < n; k++) begin
`ifdef LOADER_CHECKSUM_EN
      cs = cs ^ img[k][7:0] ^ img[k][15:8] ^ img[k][23:16] ^ img[k][31:24];
`endif
      send_word(img[k]);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, 1'b1);
`endif
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int w0, s0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_memwrite", 32'(Ext_MemWrite), 0);
    check("rst_start", 32'(CPU_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_error", 32'(load_error), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_data", Ext_WriteData, 0);
    check("rst_addr", Ext_DataAdr, 0);
    reset_n = 1'b1;
    @(posedge clk);

    // short low glitch must not start a byte
    #1 uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_error", 32'(load_error), 0);

    // N=1, DEADBEEF
    w0 = n_wr; s0 = n_start;
    send_byte(8'h01, 1'b1);
    check("t1_busy_after_len_lo", 32'(busy), 1);
    send_byte(8'h00, 1'b1);
    send_word(32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22, 1'b1);
`endif
    check("t1_writes", 32'(n_wr - w0), 1);
    check("t1_addr", log_addr[w0], 32'h100);
    check("t1_data", log_data[w0], 32'hDEADBEEF);
    check("t1_starts", 32'(n_start - s0), 1);
`ifndef LOADER_CHECKSUM_EN
    check("t1_start_latency", 32'(last_start_cyc - last_wr_cyc), 1);
`endif
    check("t1_words", 32'(words_loaded), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_error", 32'(load_error), 0);

    // N=3 back to back without reset
    w0 = n_wr; s0 = n_start;
    img[0] = 32'h00000013; img[1] = 32'h00500093; img[2] = 32'hFE000EE3;
    send_image(3);
    check("t2_writes", 32'(n_wr - w0), 3);
    check("t2_addr0", log_addr[w0], 32'h100);
    check("t2_data0", log_data[w0], 32'h00000013);
    check("t2_addr1", log_addr[w0+1], 32'h104);
    check("t2_data1", log_data[w0+1], 32'h00500093);
    check("t2_addr2", log_addr[w0+2], 32'h108);
    check("t2_data2", log_data[w0+2], 32'hFE000EE3);
    check("t2_starts", 32'(n_start - s0), 1);
    check("t2_words", 32'(words_loaded), 3);

    // zero length, then length 257
    w0 = n_wr; s0 = n_start;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t3_len0_error", 32'(load_error), 1);
    check("t3_len0_busy", 32'(busy), 0);
    do_reset();
    check("t3_error_cleared", 32'(load_error), 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    check("t3_len257_error", 32'(load_error), 1);
    send_word(32'h04030201);
    send_word(32'h08070605);
    check("t3_writes", 32'(n_wr - w0), 0);
    check("t3_starts", 32'(n_start - s0), 0);
    check("t3_still_error", 32'(load_error), 1);

    // framing error on the third data byte
    do_reset();
    w0 = n_wr; s0 = n_start;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    send_word(32'h88776655);
    check("t4_writes", 32'(n_wr - w0), 0);
    check("t4_starts", 32'(n_start - s0), 0);
    check("t4_error", 32'(load_error), 1);
    check("t4_busy", 32'(busy), 0);

    // reset mid-image, then a clean N=1 frame
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h44332211);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("t5_words_before_reset", 32'(words_loaded), 1);
    #3 reset_n = 1'b0;
    #2;
    check("t5_async_words", 32'(words_loaded), 0);
    check("t5_async_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = n_wr; s0 = n_start;
    img[0] = 32'h12345678;
    send_image(1);
    check("t5_writes", 32'(n_wr - w0), 1);
    check("t5_addr", log_addr[w0], 32'h100);
    check("t5_data", log_data[w0], 32'h12345678);
    check("t5_starts", 32'(n_start - s0), 1);
    check("t5_words", 32'(words_loaded), 1);

`ifdef LOADER_CHECKSUM_EN
    // checksum good and bad
    do_reset();
    w0 = n_wr; s0 = n_start;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h44332211);
    send_byte(8'h44, 1'b1);
    check("t6_good_starts", 32'(n_start - s0), 1);
    check("t6_good_error", 32'(load_error), 0);
    do_reset();
    w0 = n_wr; s0 = n_start;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h44332211);
    send_byte(8'h45, 1'b1);
    check("t6_bad_writes", 32'(n_wr - w0), 1);
    check("t6_bad_starts", 32'(n_start - s0), 0);
    check("t6_bad_error", 32'(load_error), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader that sits upstream of the CPU driver and data memory.
- Receives a program image over a UART RX line and assembles little-endian 32-bit words.
- Writes each word through the external memory-write port (Ext_MemWrite / Ext_WriteData / Ext_DataAdr).
- After the last word is written, issues a one-cycle CPU_start pulse that kicks the driver's reset/run sequence.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum legal value 8.
- MAX_WORDS, 256, largest accepted image length in words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word k is written at BASE_ADDR + 4*k.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- uart_rx  input  1  async serial in, 8N1, idle high.
- Ext_MemWrite  output  1  one-cycle write strobe to memory.
- Ext_WriteData  output  32  word being written.
- Ext_DataAdr  output  32  byte address of the write.
- CPU_start  output  1  one-cycle pulse when the image is fully loaded.
- busy  output  1  high from the first length byte until CPU_start or error.
- load_error  output  1  sticky error flag; cleared only by reset_n.
- words_loaded  output  16  count of words written in the current or last image.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; RX in idle.
- RX front end:
  - uart_rx passes through a 2-flop synchroniser.
  - A falling edge starts a bit counter; the start bit is re-checked at CLKS_PER_BIT/2.
  - A high start bit at the re-check is a glitch: return to RX idle, no byte produced.
  - Each data bit is sampled at mid-bit, LSB first.
  - The stop bit is sampled at mid-bit. Stop=0 is a framing error: byte discarded, FSM goes to ERROR.
  - A valid byte raises an internal 1-cycle byte_valid, 9.5 bit-times after the start edge.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4N data bytes, little-endian per word.
- FSM states:
  - IDLE: byte → store LEN_LO, set busy, go LEN_HI.
  - LEN_HI: byte → form N.
    - N==0 or N>MAX_WORDS → ERROR.
    - Otherwise clear words_loaded and byte index, go DATA.
  - DATA: shift each byte into the word register, byte 0 into bits [7:0].
    - On the 4th byte go WRITE the next cycle.
  - WRITE: single cycle.
    - Ext_MemWrite=1, Ext_WriteData=word, Ext_DataAdr=BASE_ADDR+{words_loaded,2'b00}.
    - words_loaded increments on the same edge.
    - If words_loaded+1==N go DONE (or CHECK when the option is enabled), else DATA.
  - DONE: CPU_start=1 for exactly one cycle; busy drops the same cycle; go IDLE.
    - words_loaded holds until the next LEN_HI.
  - ERROR: load_error=1, busy=0, no writes, no CPU_start; bytes ignored until reset_n.
- Ext_WriteData and Ext_DataAdr hold their last values when Ext_MemWrite=0.
- Latency: Ext_MemWrite asserts 1 cycle after byte_valid of the 4th byte; CPU_start asserts 1 cycle after the last WRITE.
- Address arithmetic is 32-bit and wraps modulo 2^32, with no carry out.
- WRITE lasts 1 cycle, far shorter than a byte time, so a byte can never arrive during WRITE and no overrun is possible.
- reset_n asserted mid-image: partial word discarded, no strobe, FSM to IDLE; the sender must resend the whole frame.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CHECK and waits for one extra byte.
  - The expected byte is the XOR of all 4N data bytes; length bytes are excluded.
  - Match → DONE. Mismatch → ERROR with no CPU_start; words already written remain in memory.
- Undefined: no CHECK state; DONE follows the last WRITE directly. A trailing byte is treated as the LEN_LO of a new frame.

Test Plan:
- Load N=1, bytes 01 00 | EF BE AD DE → one Ext_MemWrite, Ext_DataAdr=0x0, Ext_WriteData=0xDEADBEEF; CPU_start pulses 1 cycle; words_loaded=1.
- Load N=3, words 0x00000013, 0x00500093, 0xFE000EE3 with BASE_ADDR=0x100 → writes at 0x100/0x104/0x108 in order; exactly 3 strobes, then 1 CPU_start.
- Send length 00 00, then separately 01 01 (N=257 > 256) → load_error=1, no strobes, no CPU_start; further bytes ignored until reset_n.
- N=2 frame with the stop bit forced 0 on data byte 3 → no write for that word, load_error=1, busy=0.
- Assert reset_n low after 6 data bytes of an N=2 frame, release, then send a clean N=1 frame → exactly one write at 0x0, words_loaded=1, CPU_start pulses.
- With LOADER_CHECKSUM_EN defined: N=1 data 11 22 33 44, checksum 44 → CPU_start; same data with checksum 45 → load_error=1, no CPU_start.
